// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared state encoding and count width for the skid register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int COUNT_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic logic [COUNT_W-1:0] state_count(input state_t s);
    case (s)
      ONE:     state_count = 2'd1;
      TWO:     state_count = 2'd2;
      default: state_count = 2'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_data_reg.sv
// ============================================================================
// Module : pipe_data_reg
// Brief  : Enable-loaded data register with async reset and sync clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_data_reg #(
  parameter int                   DATA_SIZE     = 32,
  parameter logic [DATA_SIZE-1:0] INITIAL_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic [DATA_SIZE-1:0] d_i,
  output logic [DATA_SIZE-1:0] q_o
);

  logic [DATA_SIZE-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= INITIAL_VALUE;
    end else if (clear_i) begin
      data_q <= INITIAL_VALUE;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_register.sv
// ============================================================================
// Module : pipe_skid_register
// Brief  : Two-entry valid/ready skid stage with fully registered outputs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_skid_register
  import pipe_pkg::*;
#(
  parameter int                   DATA_SIZE     = 32,
  parameter logic [DATA_SIZE-1:0] INITIAL_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [COUNT_W-1:0]   count
);

  state_t               state_q, state_d;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [COUNT_W-1:0]   count_q;

  logic                 in_xfer;
  logic                 out_xfer;
  logic                 main_load;
  logic                 skid_load;
  logic                 main_from_skid;
  logic [DATA_SIZE-1:0] main_d;
  logic [DATA_SIZE-1:0] main_q;
  logic [DATA_SIZE-1:0] skid_q;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_load = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_load = 1'b1;
        end else if (in_xfer) begin
          skid_load = 1'b1;
          state_d   = TWO;
        end else if (out_xfer) begin
          state_d   = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides everything; the data registers clear themselves.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  // Status outputs are precomputed from the next state so they leave flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
      count_q     <= state_count(state_d);
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_data_reg #(
    .DATA_SIZE     (DATA_SIZE),
    .INITIAL_VALUE (INITIAL_VALUE)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush),
    .load_i  (main_load),
    .d_i     (main_d),
    .q_o     (main_q)
  );

  pipe_data_reg #(
    .DATA_SIZE     (DATA_SIZE),
    .INITIAL_VALUE (INITIAL_VALUE)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush),
    .load_i  (skid_load),
    .d_i     (in_data),
    .q_o     (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = count_q;

endmodule

`default_nettype wire
